// File: rtl/pll_lock_supervisor.sv
// Core PLL bring-up sequencer: pulses the PLL reset, waits for lock, qualifies lock stability,
// then releases the system reset. Bounded retries on lock timeout, latched fault afterwards.
module pll_lock_supervisor #(
    parameter int unsigned SYNC_STAGES         = 2,
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
    parameter int unsigned MAX_RETRIES         = 7,
    parameter int unsigned CNT_W               = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       pll_ok,
    output logic       fault,
    output logic [2:0] retry_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StPllReset = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFault    = 3'd4
    } state_e;

    // Terminal counts: the transition fires on the last cycle spent in the state.
    localparam logic [CNT_W-1:0] RstLast     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax      = '1;
    localparam logic [2:0]       RetryMax    = 3'(MAX_RETRIES);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             retry_q, retry_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    assign locked_s  = sync_q[SYNC_STAGES-1];
    assign state     = state_q;
    assign retry_cnt = retry_q;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (force_relock) begin
            state_d = StPllReset;
            retry_d = '0;
        end else begin
            unique case (state_q)
                StPllReset: if (cnt_q == RstLast) state_d = StWaitLock;
                StWaitLock: begin
                    if (locked_s) begin
                        state_d = StStable;
                    end else if (cnt_q == TimeoutLast) begin
                        if (retry_q < RetryMax) begin
                            retry_d = retry_q + 3'd1;
                            state_d = StPllReset;
                        end else begin
                            state_d = StFault;
                        end
                    end
                end
                StStable: begin
                    if (!locked_s) state_d = StWaitLock;
                    else if (cnt_q == StableLast) state_d = StRun;
                end
                StRun:   if (!locked_s) state_d = StPllReset;
                StFault: state_d = StFault;
                default: state_d = StPllReset;
            endcase
        end
        if (state_d == StRun && state_q != StRun) retry_d = '0;
        // A forced relock re-enters PLL_RESET even from PLL_RESET, so it restarts the count.
        if (force_relock || state_d != state_q) cnt_d = '0;
        else if (cnt_q == CntMax) cnt_d = cnt_q;
        else cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= StPllReset;
            cnt_q     <= '0;
            retry_q   <= '0;
            sync_q    <= '0;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            pll_ok    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], locked};
            pll_rst   <= (state_d == StPllReset) || (state_d == StFault);
            sys_reset <= (state_d != StRun);
            pll_ok    <= (state_d == StRun);
            fault     <= (state_d == StFault);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scenario bench for pll_lock_supervisor with short cycle counts; expectations are queued as
// stimulus is applied and compared against the observed DUT behaviour at the end of each scenario.
module tb_pll_lock_supervisor;

    localparam int ResetVec = 'b1100000000; // pll_rst,sys_reset,pll_ok,fault,retry[2:0],state[2:0]
    localparam int RunVec   = 'b0010000011;
    localparam int FaultVec = 'b1101010100;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst, sys_reset, pll_ok, fault;
    logic [2:0] retry_cnt, state;

    typedef struct {
        string name;
        int    val;
    } exp_t;

    exp_t exp_q[$];
    int   obs_q[$];
    int   total = 0;
    int   bad = 0;

    pll_lock_supervisor #(
        .SYNC_STAGES(2),
        .PLL_RST_CYCLES(4),
        .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES(2),
        .CNT_W(8)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .locked(locked),
        .force_relock(force_relock),
        .pll_rst(pll_rst),
        .sys_reset(sys_reset),
        .pll_ok(pll_ok),
        .fault(fault),
        .retry_cnt(retry_cnt),
        .state(state)
    );

    always #5 refclk = ~refclk;

    function automatic int outs();
        return int'({pll_rst, sys_reset, pll_ok, fault, retry_cnt, state});
    endfunction

    function automatic int sig(input int sel);
        case (sel)
            0:       return int'(pll_rst);
            1:       return int'(sys_reset);
            2:       return int'(pll_ok);
            default: return int'(state);
        endcase
    endfunction

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // Ticks until the selected signal equals val; n = -1 if the budget runs out.
    task automatic ticks_until(input int sel, input int val, input int budget, output int n);
        n = 0;
        while (sig(sel) != val && n < budget) begin
            tick();
            n++;
        end
        if (sig(sel) != val) n = -1;
    endtask

    task automatic test_reset();
        exp_t e;
        int   o;
        rst = 1'b1;
        locked = 1'b0;
        exp_q.push_back('{name: "reset_outputs", val: ResetVec});
        repeat (3) tick();
        obs_q.push_back(outs());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_normal();
        exp_t e;
        int   o, n;
        exp_q.push_back('{name: "first_pll_rst_len", val: 4});
        rst = 1'b0;
        ticks_until(0, 0, 20, n);
        obs_q.push_back(n);
        repeat (5) tick();
        locked = 1'b1;
        exp_q.push_back('{name: "lock_to_release", val: 11});
        ticks_until(1, 0, 50, n);
        obs_q.push_back(n);
        exp_q.push_back('{name: "run_outputs", val: RunVec});
        obs_q.push_back(outs());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_retry_fault();
        exp_t e;
        int   o, n, viol;
        rst = 1'b1;
        locked = 1'b0;
        tick();
        rst = 1'b0;
        for (int a = 0; a < 3; a++) begin
            exp_q.push_back('{name: "retry_pll_rst_len", val: 4});
            ticks_until(0, 0, 20, n);
            obs_q.push_back(n);
            exp_q.push_back('{name: "timeout_len", val: 32});
            ticks_until(0, 1, 60, n);
            obs_q.push_back(n);
            exp_q.push_back('{name: "retry_count", val: (a < 2) ? a + 1 : 2});
            obs_q.push_back(int'(retry_cnt));
        end
        exp_q.push_back('{name: "fault_outputs", val: FaultVec});
        obs_q.push_back(outs());
        exp_q.push_back('{name: "fault_held", val: 0});
        viol = 0;
        repeat (40) begin
            tick();
            if (outs() != FaultVec) viol++;
        end
        obs_q.push_back(viol);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_force_relock();
        exp_t e;
        int   o, n;
        force_relock = 1'b1;
        exp_q.push_back('{name: "force_outputs", val: ResetVec});
        tick();
        force_relock = 1'b0;
        obs_q.push_back(outs());
        locked = 1'b1;
        exp_q.push_back('{name: "force_reaches_run", val: 1});
        ticks_until(2, 1, 100, n);
        obs_q.push_back(int'(n >= 0));
        exp_q.push_back('{name: "force_run_outputs", val: RunVec});
        obs_q.push_back(outs());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_stable_glitch();
        exp_t e;
        int   o, n;
        rst = 1'b1;
        locked = 1'b0;
        tick();
        rst = 1'b0;
        ticks_until(0, 0, 20, n);
        locked = 1'b1;
        exp_q.push_back('{name: "enter_stable", val: 1});
        ticks_until(3, 2, 40, n);
        obs_q.push_back(int'(n >= 0));
        repeat (5) tick();
        locked = 1'b0;
        exp_q.push_back('{name: "glitch_to_wait", val: 3});
        tick();
        locked = 1'b1;
        ticks_until(3, 1, 10, n);
        obs_q.push_back(n + 1);
        exp_q.push_back('{name: "glitch_sys_reset", val: 1});
        obs_q.push_back(int'(sys_reset));
        exp_q.push_back('{name: "restable", val: 1});
        ticks_until(3, 2, 10, n);
        obs_q.push_back(n);
        exp_q.push_back('{name: "fresh_stable_len", val: 8});
        ticks_until(3, 3, 40, n);
        obs_q.push_back(n);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_run_loss();
        exp_t e;
        int   o, n;
        locked = 1'b0;
        exp_q.push_back('{name: "loss_to_sys_reset", val: 3});
        ticks_until(1, 1, 10, n);
        obs_q.push_back(n);
        exp_q.push_back('{name: "loss_pll_rst", val: 1});
        obs_q.push_back(int'(pll_rst));
        exp_q.push_back('{name: "loss_retry", val: 0});
        obs_q.push_back(int'(retry_cnt));
        exp_q.push_back('{name: "loss_pll_rst_len", val: 4});
        ticks_until(0, 0, 20, n);
        obs_q.push_back(n);
        locked = 1'b1;
        exp_q.push_back('{name: "relock_run", val: RunVec});
        ticks_until(2, 1, 100, n);
        obs_q.push_back(outs());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   o, n;
        rst = 1'b1;
        locked = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.push_back('{name: "enter_wait_lock", val: 4});
        ticks_until(3, 1, 20, n);
        obs_q.push_back(n);
        repeat (3) tick();
        #3;
        rst = 1'b1;
        #1;
        exp_q.push_back('{name: "async_reset_outputs", val: ResetVec});
        obs_q.push_back(outs());
        #2;
        rst = 1'b0;
        exp_q.push_back('{name: "restart_pll_rst_len", val: 4});
        ticks_until(0, 0, 20, n);
        obs_q.push_back(n);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.name, o, e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_retry_fault();
        test_force_relock();
        test_stable_glitch();
        test_run_loss();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
